shadow_bank_regfile: RTL
========================

SHADOW_BANK_REGFILE -- requirements
Module: shadow_bank_regfile

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 64, the width of each register in bits.
REQ-002 The block SHALL take parameter NR_READ_PORTS, default 2, the number of architectural read ports.
REQ-003 The block SHALL take parameter NR_WRITE_PORTS, default 2, the number of architectural write ports.
REQ-004 The block SHALL take parameter NR_BANKS, default 4, the number of nested shadow banks (minimum 1).
REQ-005 The block SHALL take parameter ZERO_REG_ZERO, default 1; when set, x0 reads 0 and ignores writes.
REQ-006 The block SHALL have these ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- raddr_i  in  NR_READ_PORTS x 5  read addresses.
- rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data.
- waddr_i, wdata_i, we_i  in  NR_WRITE_PORTS x (5 / DATA_WIDTH / 1)  write ports.
- save_valid_i / save_ready_o  in / out  1 / 1  push handshake.
- restore_valid_i / restore_ready_o  in / out  1 / 1  pop handshake.
- sh_raddr_i / sh_rdata_o  in / out  4 / DATA_WIDTH  top-bank read.
- sh_waddr_i, sh_wdata_i, sh_we_i  in  4 / DATA_WIDTH / 1  top-bank write.
- depth_o  out  $clog2(NR_BANKS+1)  occupied banks.
- full_o, empty_o, overflow_o  out  1 each  status flags.
- sp_o  out  DATA_WIDTH  current x2.

Function
REQ-007 Saved set SHALL be 16 entries in order: x1, x5, x6, x7, x10-x17, x28-x31 (slots 0..15); FRAME SHALL equal 16*DATA_WIDTH/8.
REQ-008 Architectural writes SHALL take effect at the next clk_i edge; for same-address writes on several ports, the highest port index SHALL win.
REQ-009 save_ready_o SHALL equal !full_o && !restore_valid_i; restore_ready_o SHALL equal !empty_o.
REQ-010 On an accepted save, bank[depth] SHALL capture the pre-edge saved set, and depth SHALL increment by 1.
REQ-011 On an accepted save, x2 SHALL become (same-cycle write data to x2 if any, else x2) - FRAME, so no sp write is lost.
REQ-012 On an accepted restore, the saved set SHALL load from bank[depth-1], overriding same-cycle architectural writes to those registers, and depth SHALL decrement by 1.
REQ-013 On an accepted restore, x2 SHALL become (same-cycle x2 write data if any, else x2) + FRAME.
REQ-014 Arithmetic on x2 SHALL be modulo 2^DATA_WIDTH.
REQ-015 When save_valid_i and restore_valid_i are both high, restore SHALL win, so only one handshake completes per cycle.
REQ-016 save_valid_i while full_o SHALL set overflow_o sticky, with no state change.
REQ-017 restore_valid_i while empty_o SHALL be ignored.
REQ-018 sh_rdata_o SHALL be combinational bank[depth-1][sh_raddr_i], or 0 when empty.
REQ-019 A shadow write SHALL update bank[depth-1][sh_waddr_i] next edge; it SHALL be dropped when empty or when a save/restore is accepted the same cycle.
REQ-020 full_o SHALL equal (depth==NR_BANKS), and empty_o SHALL equal (depth==0).
REQ-021 sp_o SHALL equal registered x2.

Reset
REQ-022 rst_ni low SHALL asynchronously clear all registers and banks to 0, depth_o to 0, and overflow_o to 0; empty_o SHALL then read 1 and full_o SHALL read 0.
REQ-023 Reset mid-handshake SHALL abort it, leaving no partial bank or sp update after deassertion.

Configuration
REQ-024 With macro SHADOW_BANK_WRITE_FWD_EN defined, rdata_o SHALL forward same-cycle write data for a matching enabled write (highest port wins, never for x0 when ZERO_REG_ZERO); undefined, rdata_o SHALL return registered contents only.

Verification
REQ-025 A bench SHALL cover: reset, then x2=0x1000, x10=0xA; save -> depth 1, x2=0xF80, sh_raddr=4 gives 0xA.
REQ-026 A bench SHALL cover: after that save, write x10=0xB, then restore -> x10=0xA, x2=0x1000, empty_o=1.
REQ-027 A bench SHALL cover: NR_BANKS=4, five saves -> fifth not accepted, full_o=1, overflow_o=1, depth_o=4.
REQ-028 A bench SHALL cover: save with a same-cycle write x2=0x2000 -> x2=0x1F80.
REQ-029 A bench SHALL cover: save_valid and restore_valid together at depth 2 -> restore only, depth 1.
REQ-030 A bench SHALL cover: write x5=0x55 and read x5 same cycle -> 0x55 with SHADOW_BANK_WRITE_FWD_EN defined, old value without it.

Source files
------------

// File: rtl/shadow_bank_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : shadow_bank_regfile
//  Purpose  : 32-entry register file with a stack of shadow banks that save
//             and restore the 16 caller-saved registers, adjusting x2 by one frame.
//  Option   : SHADOW_BANK_WRITE_FWD_EN forwards same-cycle write data to rdata_o.
//  Revision : 1.0
// ============================================================================
module shadow_bank_regfile #(
   parameter int DATA_WIDTH     = 64,
   parameter int NR_READ_PORTS  = 2,
   parameter int NR_WRITE_PORTS = 2,
   parameter int NR_BANKS       = 4,
   parameter int ZERO_REG_ZERO  = 1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NR_READ_PORTS*5-1:0]             raddr_i,
   output logic [NR_READ_PORTS*DATA_WIDTH-1:0]    rdata_o,
   input  logic [NR_WRITE_PORTS*5-1:0]            waddr_i,
   input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]   wdata_i,
   input  logic [NR_WRITE_PORTS-1:0]              we_i,
   input  logic                                   save_valid_i,
   output logic                                   save_ready_o,
   input  logic                                   restore_valid_i,
   output logic                                   restore_ready_o,
   input  logic [3:0]                             sh_raddr_i,
   output logic [DATA_WIDTH-1:0]                  sh_rdata_o,
   input  logic [3:0]                             sh_waddr_i,
   input  logic [DATA_WIDTH-1:0]                  sh_wdata_i,
   input  logic                                   sh_we_i,
   output logic [$clog2(NR_BANKS+1)-1:0]          depth_o,
   output logic                                   full_o,
   output logic                                   empty_o,
   output logic                                   overflow_o,
   output logic [DATA_WIDTH-1:0]                  sp_o
);

   localparam int                    c_dpw   = $clog2(NR_BANKS+1);
   localparam logic [DATA_WIDTH-1:0] c_frame = DATA_WIDTH'(2*DATA_WIDTH);

   logic [DATA_WIDTH-1:0] r_regs [32];
   logic [DATA_WIDTH-1:0] r_bank [NR_BANKS][16];
   logic [c_dpw-1:0]      r_depth;
   logic                  r_overflow;

   logic [DATA_WIDTH-1:0] w_next [32];
   logic [DATA_WIDTH-1:0] w_top  [16];
   logic                  w_full, w_empty, w_save_acc, w_restore_acc;

   // Slot order: x1, x5-x7, x10-x17, x28-x31
   function automatic logic [4:0] slot_reg(input logic [3:0] s);
      if (s == 4'd0)       return 5'd1;
      else if (s <= 4'd3)  return {1'b0, s} + 5'd4;
      else if (s <= 4'd11) return {1'b0, s} + 5'd6;
      else                 return {1'b0, s} + 5'd16;
   endfunction

   assign w_full        = (r_depth == c_dpw'(NR_BANKS));
   assign w_empty       = (r_depth == '0);
   assign w_restore_acc = restore_valid_i && !w_empty;
   assign w_save_acc    = save_valid_i && !w_full && !restore_valid_i;

   assign save_ready_o    = !w_full && !restore_valid_i;
   assign restore_ready_o = !w_empty;
   assign full_o          = w_full;
   assign empty_o         = w_empty;
   assign overflow_o      = r_overflow;
   assign depth_o         = r_depth;
   assign sp_o            = r_regs[2];

   always_comb begin
      for (int s = 0; s < 16; s++) w_top[s] = '0;
      for (int b = 0; b < NR_BANKS; b++) begin
         if (r_depth == c_dpw'(b+1)) begin
            for (int s = 0; s < 16; s++) w_top[s] = r_bank[b][s];
         end
      end
   end

   assign sh_rdata_o = w_top[sh_raddr_i];

   // Restore overrides architectural writes to saved slots; x2 is adjusted after writes
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         w_next[i] = r_regs[i];
         for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            if (we_i[p] && waddr_i[p*5 +: 5] == 5'(i))
               w_next[i] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (ZERO_REG_ZERO != 0) w_next[0] = '0;
      if (w_save_acc)         w_next[2] = w_next[2] - c_frame;
      else if (w_restore_acc) w_next[2] = w_next[2] + c_frame;
      if (w_restore_acc) begin
         for (int s = 0; s < 16; s++) w_next[slot_reg(4'(s))] = w_top[s];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
         for (int b = 0; b < NR_BANKS; b++)
            for (int s = 0; s < 16; s++) r_bank[b][s] <= '0;
         r_depth    <= '0;
         r_overflow <= 1'b0;
      end else begin
         for (int i = 0; i < 32; i++) r_regs[i] <= w_next[i];
         if (w_save_acc) begin
            for (int b = 0; b < NR_BANKS; b++) begin
               if (r_depth == c_dpw'(b))
                  for (int s = 0; s < 16; s++) r_bank[b][s] <= r_regs[slot_reg(4'(s))];
            end
            r_depth <= r_depth + c_dpw'(1);
         end else if (w_restore_acc) begin
            r_depth <= r_depth - c_dpw'(1);
         end else if (sh_we_i && !w_empty) begin
            for (int b = 0; b < NR_BANKS; b++) begin
               if (r_depth == c_dpw'(b+1)) r_bank[b][sh_waddr_i] <= sh_wdata_i;
            end
         end
         if (save_valid_i && w_full) r_overflow <= 1'b1;
      end
   end

   for (genvar r = 0; r < NR_READ_PORTS; r++) begin : g_rd
      logic [4:0]            w_ra;
      logic [DATA_WIDTH-1:0] w_rd;
      assign w_ra = raddr_i[r*5 +: 5];
      always_comb begin
         w_rd = r_regs[w_ra];
`ifdef SHADOW_BANK_WRITE_FWD_EN
         for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            if (we_i[p] && waddr_i[p*5 +: 5] == w_ra)
               w_rd = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
         end
`endif
         if (ZERO_REG_ZERO != 0 && w_ra == 5'd0) w_rd = '0;
      end
      assign rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = w_rd;
   end

endmodule
`default_nettype wire
